// File: rtl/nv_clk_gate_pkg.sv
// nv_clk_gate_pkg: shared types and defaults for the multi-channel power
// clock-gate controller (nv_clk_gate_power_ctrl and its gate cell).
package nv_clk_gate_pkg;

  // Per-channel gate FSM states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    GATED = 2'd2
  } gate_state_e;

  // Default width of the idle hold-off count.
  localparam int DEF_HOLD_W = 4;

  // Default width of the optional per-channel gated-cycle counters.
  localparam int DEF_CNT_W = 16;

  // State a channel wakes up in, given its reset-time gate enable.
  function automatic gate_state_e reset_state(input logic rst_en);
    return rst_en ? RUN : GATED;
  endfunction

endpackage

// File: rtl/nv_clk_gate_cell.sv
// nv_clk_gate_cell: glitch-free latch-based clock gate.
// The enable and the test override are captured by latches that are
// transparent while clk is low, so they can only change the gated clock
// at the next rising edge and never truncate a high phase.
// This is the single point where a technology ICG replaces the behavioural
// latch + AND.
module nv_clk_gate_cell #(
  parameter bit RST_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_,
  input  logic en,
  input  logic test_en,
  output logic clk_gated
);

  logic en_lat_reg;
  logic test_en_lat_reg;

  // Low-phase transparent latches; reset forces a known enable so the
  // gated clock is never X once reset has been applied.
  always_latch begin
    if (!reset_) begin
      en_lat_reg      <= RST_EN;
      test_en_lat_reg <= 1'b0;
    end else if (!clk) begin
      en_lat_reg      <= en;
      test_en_lat_reg <= test_en;
    end
  end

  assign clk_gated = clk & (en_lat_reg | test_en_lat_reg);

endmodule

// File: rtl/nv_clk_gate_power_ctrl.sv
// nv_clk_gate_power_ctrl: multi-channel power clock-gate controller.
// Each channel runs a RUN/HOLD/GATED FSM with a programmable idle hold-off
// and drives one nv_clk_gate_cell. Channels are fully independent.
// Optional build macro NV_CLK_GATE_PERF_EN adds per-channel saturating
// gated-cycle counters (gated_cnt) with a synchronous clear (perf_clr).
module nv_clk_gate_power_ctrl
  import nv_clk_gate_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int HOLD_W = DEF_HOLD_W,
  parameter bit RST_EN = 1'b1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic [NCH-1:0]       clk_en,
  input  logic                 test_en,
  input  logic [HOLD_W-1:0]    idle_hold,
`ifdef NV_CLK_GATE_PERF_EN
  input  logic                 perf_clr,
  output logic [NCH*CNT_W-1:0] gated_cnt,
`endif
  output logic [NCH-1:0]       clk_gated,
  output logic [NCH-1:0]       gate_active
);

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      gate_state_e       state_reg;
      logic [HOLD_W-1:0] cnt_reg;
      logic              en_q_reg;
      logic              gate_active_reg;

      // Gate FSM: hold the clock for idle_hold extra cycles after the
      // request drops; idle_hold is sampled only on entry to HOLD.
      always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
          state_reg       <= reset_state(RST_EN);
          cnt_reg         <= '0;
          en_q_reg        <= RST_EN;
          gate_active_reg <= ~RST_EN;
        end else begin
          case (state_reg)
            RUN: begin
              if (!clk_en[gi]) begin
                if (idle_hold == '0) begin
                  state_reg       <= GATED;
                  en_q_reg        <= 1'b0;
                  gate_active_reg <= 1'b1;
                end else begin
                  state_reg <= HOLD;
                  cnt_reg   <= idle_hold - HOLD_ONE;
                end
              end
            end
            HOLD: begin
              if (clk_en[gi]) begin
                state_reg <= RUN;
                cnt_reg   <= '0;
              end else if (cnt_reg == '0) begin
                state_reg       <= GATED;
                en_q_reg        <= 1'b0;
                gate_active_reg <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg - HOLD_ONE;
              end
            end
            GATED: begin
              // Enable rises on this edge; first pulse follows one cycle later.
              if (clk_en[gi]) begin
                state_reg       <= RUN;
                en_q_reg        <= 1'b1;
                gate_active_reg <= 1'b0;
              end
            end
            default: begin
              state_reg       <= reset_state(RST_EN);
              cnt_reg         <= '0;
              en_q_reg        <= RST_EN;
              gate_active_reg <= ~RST_EN;
            end
          endcase
        end
      end

      assign gate_active[gi] = gate_active_reg;

      nv_clk_gate_cell #(
        .RST_EN (RST_EN)
      ) u_cell (
        .clk       (clk),
        .reset_    (reset_),
        .en        (en_q_reg),
        .test_en   (test_en),
        .clk_gated (clk_gated[gi])
      );

`ifdef NV_CLK_GATE_PERF_EN
      logic [CNT_W-1:0] perf_cnt_reg;

      // Count cycles the channel is truly stopped (gated and not overridden
      // by test_en); saturates, and a clear wins over an increment.
      always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
          perf_cnt_reg <= '0;
        end else if (perf_clr) begin
          perf_cnt_reg <= '0;
        end else if (!en_q_reg && !test_en && (perf_cnt_reg != '1)) begin
          perf_cnt_reg <= perf_cnt_reg + CNT_W'(1);
        end
      end

      assign gated_cnt[gi*CNT_W +: CNT_W] = perf_cnt_reg;
`else
      // Without the counters CNT_W sizes nothing; this empty block keeps the
      // parameter referenced so both builds share one parameter list.
      if (CNT_W < 1) begin : g_no_perf_cnt
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_nv_clk_gate_power_ctrl.sv
// tb_nv_clk_gate_power_ctrl: directed bench for nv_clk_gate_power_ctrl.
// The reference model tracks, per channel, how many consecutive low samples
// of clk_en have been seen and the hold-off captured at the first of them;
// the gate is closed once that run reaches hold+1. Define
// NV_CLK_GATE_PERF_EN to also exercise the gated-cycle counters.
module tb_nv_clk_gate_power_ctrl;

  localparam int NCH    = 4;
  localparam int HOLD_W = 4;
`ifdef NV_CLK_GATE_PERF_EN
  localparam int CNT_W  = 4;
`else
  localparam int CNT_W  = 16;
`endif

  logic              clk = 1'b0;
  logic              reset_;
  logic [NCH-1:0]    clk_en;
  logic              test_en;
  logic [HOLD_W-1:0] idle_hold;
  wire  [NCH-1:0]    clk_gated;
  wire  [NCH-1:0]    gate_active;
`ifdef NV_CLK_GATE_PERF_EN
  logic                 perf_clr;
  wire  [NCH*CNT_W-1:0] gated_cnt;
`endif

  always #5 clk = ~clk;

  nv_clk_gate_power_ctrl #(
    .NCH    (NCH),
    .HOLD_W (HOLD_W),
    .RST_EN (1'b1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset_      (reset_),
    .clk_en      (clk_en),
    .test_en     (test_en),
    .idle_hold   (idle_hold),
`ifdef NV_CLK_GATE_PERF_EN
    .perf_clr    (perf_clr),
    .gated_cnt   (gated_cnt),
`endif
    .clk_gated   (clk_gated),
    .gate_active (gate_active)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse counters on each gated clock.
  int p0 = 0, p1 = 0, p2 = 0, p3 = 0;
  always @(posedge clk_gated[0]) p0++;
  always @(posedge clk_gated[1]) p1++;
  always @(posedge clk_gated[2]) p2++;
  always @(posedge clk_gated[3]) p3++;

  // Every high pulse on channel 1 must be exactly half a period wide.
  longint rise1 = 0;
  always @(posedge clk_gated[1]) rise1 = $time;
  always @(negedge clk_gated[1]) chk("pulse_width_ch1", $time - rise1, 5);

  // Reference model state.
  bit m_en  [NCH] = '{default: 1'b1};
  int m_low [NCH] = '{default: 0};
  int m_cap [NCH] = '{default: 0};
  int m_cnt [NCH] = '{default: 0};

  // Compare process: update the model at each edge, then check outputs in
  // the high phase and again in the low phase.
  always @(posedge clk) begin
    bit [NCH-1:0] le;
    bit           lt;
    bit [NCH-1:0] exp_gc;
    bit [NCH-1:0] exp_ga;
`ifdef NV_CLK_GATE_PERF_EN
    logic [NCH*CNT_W-1:0] exp_cnt;
`endif
    lt = reset_ ? test_en : 1'b0;
    for (int i = 0; i < NCH; i++) begin
      le[i] = reset_ ? m_en[i] : 1'b1;
`ifdef NV_CLK_GATE_PERF_EN
      if (!reset_ || perf_clr) m_cnt[i] = 0;
      else if (!le[i] && !lt && m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
`endif
      if (!reset_) begin
        m_en[i]  = 1'b1;
        m_low[i] = 0;
      end else if (clk_en[i]) begin
        m_en[i]  = 1'b1;
        m_low[i] = 0;
      end else begin
        if (m_low[i] == 0) m_cap[i] = int'(idle_hold);
        m_low[i]++;
        if (m_low[i] >= m_cap[i] + 1) m_en[i] = 1'b0;
      end
    end
    #2;
    for (int i = 0; i < NCH; i++) begin
      exp_gc[i] = le[i] | lt;
      exp_ga[i] = ~m_en[i];
    end
    chk("clk_gated_x", $isunknown(clk_gated), 1'b0);
    chk("clk_gated_high", clk_gated, exp_gc);
    chk("gate_active", gate_active, exp_ga);
`ifdef NV_CLK_GATE_PERF_EN
    for (int i = 0; i < NCH; i++) exp_cnt[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
    chk("gated_cnt", gated_cnt, exp_cnt);
`endif
    #5;
    chk("clk_gated_low", clk_gated, 4'b0000);
  end

  int b0, b1, b2, b3;

  initial begin
    reset_    = 1'b0;
    clk_en    = '0;
    test_en   = 1'b0;
    idle_hold = 4'd3;
`ifdef NV_CLK_GATE_PERF_EN
    perf_clr  = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_gate_active", gate_active, 4'b0000);

    // 1: release with idle_hold=3, clk_en low -> 4 pulses, then gated
    reset_ = 1'b1;
    b0 = p0;
    repeat (3) tick();
    chk("t1_active_before_close", gate_active, 4'b0000);
    tick();
    chk("t1_active_after_close", gate_active, 4'b1111);
    repeat (2) tick();
    chk("t1_pulse_count", p0 - b0, 4);

    // 2: idle_hold=0, one low sample on ch1 -> exactly one missing pulse
    idle_hold = 4'd0;
    clk_en = 4'b0010;
    repeat (3) tick();
    b1 = p1;
    clk_en = 4'b0000;
    tick();
    chk("t2_closed", gate_active[1], 1'b1);
    clk_en = 4'b0010;
    tick();
    chk("t2_reopened", gate_active[1], 1'b0);
    repeat (4) tick();
    chk("t2_one_missing_pulse", p1 - b1, 5);

    // 3: idle_hold=5, ch2 low for 4 samples; idle_hold->0 during HOLD ignored
    clk_en = 4'b0110;
    repeat (2) tick();
    idle_hold = 4'd5;
    clk_en = 4'b0010;
    b2 = p2;
    tick();
    idle_hold = 4'd0;
    repeat (3) tick();
    chk("t3_hold_not_gated", gate_active[2], 1'b0);
    clk_en = 4'b0110;
    repeat (2) tick();
    chk("t3_never_gated", gate_active[2], 1'b0);
    chk("t3_no_missing_pulse", p2 - b2, 6);

    // 4: all gated, test_en for 10 cycles -> 10 pulses everywhere
    clk_en = 4'b0000;
    repeat (3) tick();
    chk("t4_all_gated", gate_active, 4'b1111);
    b0 = p0; b1 = p1; b2 = p2; b3 = p3;
    test_en = 1'b1;
    repeat (10) tick();
    test_en = 1'b0;
    chk("t4_active_during_test", gate_active, 4'b1111);
    repeat (3) tick();
    chk("t4_pulses_ch0", p0 - b0, 10);
    chk("t4_pulses_ch1", p1 - b1, 10);
    chk("t4_pulses_ch2", p2 - b2, 10);
    chk("t4_pulses_ch3", p3 - b3, 10);

    // 5a: asynchronous reset in the middle of HOLD
    idle_hold = 4'd7;
    clk_en = 4'b1111;
    repeat (2) tick();
    clk_en = 4'b0010;
    repeat (2) tick();
    #2;
    reset_ = 1'b0;
    #1;
    chk("t5_hold_reset_active", gate_active, 4'b0000);
    chk("t5_hold_reset_clk", clk_gated, 4'b1111);
    tick();
    reset_ = 1'b1;

    // 5b: asynchronous reset in the middle of GATED reopens the gate at once
    idle_hold = 4'd0;
    clk_en = 4'b1110;
    repeat (2) tick();
    chk("t5_gated_no_pulse", clk_gated[0], 1'b0);
    chk("t5_gated_status", gate_active[0], 1'b1);
    #2;
    reset_ = 1'b0;
    #1;
    chk("t5_async_status", gate_active, 4'b0000);
    chk("t5_async_clk", clk_gated, 4'b1111);
    tick();
    reset_ = 1'b1;
    clk_en = 4'b1111;
    repeat (3) tick();

`ifdef NV_CLK_GATE_PERF_EN
    // 6: counters saturate at 15; clear beats a same-cycle increment
    clk_en = 4'b0000;
    repeat (25) tick();
    chk("t6_saturated", gated_cnt[3:0], 4'd15);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("t6_cleared", gated_cnt[3:0], 4'd0);
    tick();
    chk("t6_counting_again", gated_cnt[3:0], 4'd1);
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
